// File: rtl/host_cmd_bridge.sv
// host_cmd_bridge
//   Turns host wire-in levels (address, data, R/W, channel, go) into queued
//   register commands and issues them one at a time over a req/ack handshake
//   to one of NCH downstream register engines. Read data, sticky done flags,
//   sticky error status and queue level are returned for host wire-outs.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   host_addr/wdata/rw  command fields (rw: 1 = write, 0 = read)
//   host_chan           target channel
//   host_go             rising edge enqueues one command
//   host_clr            rising edge clears flag_W, flag_R and err_code
//   host_rdata          data from the last completed read
//   flag_W / flag_R     sticky write / read completed
//   err_code            sticky, first error wins: 0 none, 1 overflow, 2 timeout
//   busy                command queued or in flight
//   fifo_level          queued command count
//   dev_req             one-hot request, held until ack or timeout
//   dev_addr/wdata/rw   issued command fields
//   dev_ack             per-channel single-cycle completion
//   dev_rdata           per-channel read data, valid with ack
module host_cmd_bridge #(
  parameter int AW      = 7,
  parameter int DW      = 8,
  parameter int NCH     = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000000,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     host_addr,
  input  logic [DW-1:0]     host_wdata,
  input  logic              host_rw,
  input  logic [CHW-1:0]    host_chan,
  input  logic              host_go,
  input  logic              host_clr,
  output logic [DW-1:0]     host_rdata,
  output logic              flag_W,
  output logic              flag_R,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [LW-1:0]     fifo_level,
  output logic [NCH-1:0]    dev_req,
  output logic [AW-1:0]     dev_addr,
  output logic [DW-1:0]     dev_wdata,
  output logic              dev_rw,
  input  logic [NCH-1:0]    dev_ack,
  input  logic [NCH*DW-1:0] dev_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [CHW-1:0] chan;
    logic           rw;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
  } cmd_t;

  state_t         state;
  cmd_t           mem [DEPTH];
  cmd_t           head;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CHW-1:0] cur_chan;
  logic           cur_rw;
  logic [TW-1:0]  timer;
  logic           go_q, clr_q;
  logic           go_edge, clr_edge;
  logic           chan_ok, fifo_full, push, pop;
  logic           ack_sel, ack_hit, timed_out;
  logic [1:0]     err_set;

  assign go_edge   = host_go & ~go_q;
  assign clr_edge  = host_clr & ~clr_q;
  assign chan_ok   = 32'(host_chan) < 32'(NCH);
  assign fifo_full = fifo_level == LW'(DEPTH);
  assign push      = go_edge & chan_ok & ~fifo_full;
  assign pop       = (state == IDLE) & (fifo_level != '0);
  assign head      = mem[rd_ptr];
  assign ack_sel   = dev_ack[cur_chan];
  assign ack_hit   = (state == WAIT) & ack_sel;
  assign timed_out = (state == WAIT) & ~ack_sel & (timer == TW'(TIMEOUT - 1));
  assign busy      = (state != IDLE) | (fifo_level != '0);

  // Overflow outranks a timeout landing on the same edge.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    err_set = ERR_NONE;
    if (go_edge && !push)
      err_set = ERR_OVF;
    else if (timed_out)
      err_set = ERR_TMO;
  end

  // NOTE: the command store has no reset; the pointers and level define
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{host_chan, host_rw, host_addr, host_wdata};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      go_q       <= 1'b0;
      clr_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      cur_chan   <= '0;
      cur_rw     <= 1'b0;
      timer      <= '0;
      host_rdata <= '0;
      flag_W     <= 1'b0;
      flag_R     <= 1'b0;
      err_code   <= ERR_NONE;
      dev_req    <= '0;
      dev_addr   <= '0;
      dev_wdata  <= '0;
      dev_rw     <= 1'b0;
    end else begin
      go_q  <= host_go;
      clr_q <= host_clr;

      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop)
        fifo_level <= fifo_level + 1'b1;
      else if (pop && !push)
        fifo_level <= fifo_level - 1'b1;

      // Sticky status: a set on the same edge as clr_edge wins.
      flag_W <= (flag_W & ~clr_edge) | ((state == DONE) & cur_rw);
      flag_R <= (flag_R & ~clr_edge) | ((state == DONE) & ~cur_rw);
      if (err_set != ERR_NONE && (err_code == ERR_NONE || clr_edge))
        err_code <= err_set;
      else if (clr_edge)
        err_code <= ERR_NONE;

      unique case (state)
        IDLE: begin
          // The bus is loaded straight from the FIFO head at pop time so
          // dev_req is already up while ISSUE clears the timer.
          if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            cur_chan  <= head.chan;
            cur_rw    <= head.rw;
            dev_addr  <= head.addr;
            dev_wdata <= head.wdata;
            dev_rw    <= head.rw;
            dev_req   <= NCH'(1) << head.chan;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (ack_hit) begin
            dev_req <= '0;
            if (!cur_rw)
              host_rdata <= dev_rdata[32'(cur_chan) * DW +: DW];
            state <= DONE;
          end else if (timed_out) begin
            dev_req <= '0;
            state   <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_cmd_bridge.sv
// Self-checking bench for host_cmd_bridge: directed scenarios with literal
// expectations, then randomized traffic; a queue-based model predicts every
// output on every cycle.
module tb_host_cmd_bridge;

  localparam int AW = 7, DW = 8, NCH = 3, DEPTH = 4, TIMEOUT = 16;
  localparam int CHW = 2, LW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     host_addr;
  logic [DW-1:0]     host_wdata;
  logic              host_rw;
  logic [CHW-1:0]    host_chan;
  logic              host_go, host_clr;
  logic [DW-1:0]     host_rdata;
  logic              flag_W, flag_R, busy;
  logic [1:0]        err_code;
  logic [LW-1:0]     fifo_level;
  logic [NCH-1:0]    dev_req, dev_ack;
  logic [AW-1:0]     dev_addr;
  logic [DW-1:0]     dev_wdata;
  logic              dev_rw;
  logic [NCH*DW-1:0] dev_rdata;

  host_cmd_bridge #(.AW(AW), .DW(DW), .NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rw(host_rw), .host_chan(host_chan), .host_go(host_go), .host_clr(host_clr),
    .host_rdata(host_rdata), .flag_W(flag_W), .flag_R(flag_R), .err_code(err_code),
    .busy(busy), .fifo_level(fifo_level), .dev_req(dev_req), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_rw(dev_rw), .dev_ack(dev_ack), .dev_rdata(dev_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- device model ----------------
  int fixed_dly = 0;   // 0: random ack delay per command
  bit never_ack = 0, spurious = 0, rd_force = 0;
  bit trk = 0, rmute = 0;
  int cnt = 0, dly = 0;

  always @(negedge clk) begin
    dev_rdata = 24'($urandom);
    if (rd_force) dev_rdata[15:8] = 8'hA7;
    dev_ack = '0;
    if (dev_req != '0) begin
      if (!trk) begin
        trk   = 1;
        cnt   = 0;
        dly   = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(2, 8));
        rmute = (fixed_dly == 0) && ($urandom_range(0, 9) == 0);
      end
      cnt++;
      if (!never_ack && !rmute && cnt >= dly) dev_ack = dev_req;
    end else begin
      trk = 0;
    end
    if (spurious && $urandom_range(0, 3) == 0)
      dev_ack = dev_ack | (3'($urandom) & ~dev_req);
  end

  // ---------------- behavioural reference ----------------
  typedef struct {
    logic [CHW-1:0] chan;
    logic           rw;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
  } cmd_s;

  cmd_s           mq[$];
  cmd_s           m_cur;
  bit             m_live, m_done, m_go_prev, m_clr_prev;
  int             m_n;                 // edges seen since the command was popped
  logic [NCH-1:0] e_req;
  logic [AW-1:0]  e_addr;
  logic [DW-1:0]  e_wdata, e_rdata;
  logic           e_rw, e_fw, e_fr;
  logic [1:0]     e_err;

  task automatic model_step();
    bit goe, clre, idle, fin_w, fin_r;
    int lvl, err_new;
    cmd_s c;
    if (rst) begin
      mq.delete();
      m_live = 0; m_done = 0; m_go_prev = 0; m_clr_prev = 0; m_n = 0;
      e_req = '0; e_addr = '0; e_wdata = '0; e_rw = 0; e_rdata = '0;
      e_fw = 0; e_fr = 0; e_err = 0;
      return;
    end
    goe  = host_go && !m_go_prev;
    clre = host_clr && !m_clr_prev;
    lvl  = mq.size();
    idle = !m_live && !m_done;
    fin_w = 0; fin_r = 0; err_new = 0;
    if (m_done) begin
      fin_w = m_cur.rw; fin_r = !m_cur.rw; m_done = 0;
    end else if (m_live) begin
      m_n++;
      // First edge after the pop is the issue cycle; acks count from the next.
      if (m_n >= 2 && dev_ack[m_cur.chan]) begin
        m_live = 0; e_req = '0; m_done = 1;
        if (!m_cur.rw) e_rdata = dev_rdata[m_cur.chan*DW +: DW];
      end else if (m_n == TIMEOUT + 1) begin
        m_live = 0; e_req = '0; err_new = 2;
      end
    end
    if (idle && lvl > 0) begin
      m_cur = mq.pop_front();
      m_live = 1; m_n = 0;
      e_req = 3'(1) << m_cur.chan;
      e_addr = m_cur.addr; e_wdata = m_cur.wdata; e_rw = m_cur.rw;
    end
    if (goe) begin
      if (host_chan >= NCH || lvl == DEPTH) err_new = 1;
      else begin
        c.chan = host_chan; c.rw = host_rw; c.addr = host_addr; c.wdata = host_wdata;
        mq.push_back(c);
      end
    end
    if (err_new != 0 && (e_err == 0 || clre)) e_err = 2'(err_new);
    else if (clre) e_err = 0;
    e_fw = (e_fw && !clre) || fin_w;
    e_fr = (e_fr && !clre) || fin_r;
    m_go_prev = host_go;
    m_clr_prev = host_clr;
  endtask

  // ---------------- per-cycle compare and monitors ----------------
  logic [AW-1:0] issued[$];
  bit prev_req_hi = 0, req0_seen = 0;
  int req_run = 0, last_run = 0;

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("cyc_dev_req", dev_req, e_req);
      check("cyc_dev_addr", dev_addr, e_addr);
      check("cyc_dev_wdata", dev_wdata, e_wdata);
      check("cyc_dev_rw", dev_rw, e_rw);
      check("cyc_host_rdata", host_rdata, e_rdata);
      check("cyc_flag_W", flag_W, e_fw);
      check("cyc_flag_R", flag_R, e_fr);
      check("cyc_err_code", err_code, e_err);
      check("cyc_fifo_level", fifo_level, mq.size());
      check("cyc_busy", busy, m_live || m_done || mq.size() != 0);
      if (dev_req != '0 && !prev_req_hi) issued.push_back(dev_addr);
      if (dev_req[0]) req0_seen = 1;
      if (dev_req != '0) req_run++;
      else if (prev_req_hi) begin last_run = req_run; req_run = 0; end
      prev_req_hi = (dev_req != '0);
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_go(input logic [1:0] ch, input logic rw, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    host_chan = ch; host_rw = rw; host_addr = a; host_wdata = d; host_go = 1;
    @(negedge clk);
    host_go = 0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); host_clr = 1;
    @(negedge clk); host_clr = 0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int i = 0;
    do begin @(posedge clk); #2; i++; end while (busy && i < max_cyc);
    check("drain_idle", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1; host_addr = '0; host_wdata = '0; host_rw = 0; host_chan = '0;
    host_go = 0; host_clr = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_dev_req", dev_req, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_flags", {flag_W, flag_R, err_code}, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); rst = 0;

    // Single write, device acks on the third cycle it sees req.
    fixed_dly = 3;
    @(negedge clk);
    host_chan = 0; host_addr = 7'h2A; host_wdata = 8'h5C; host_rw = 1; host_go = 1;
    @(posedge clk); #2;
    check("wr_level_c1", fifo_level, 1);
    check("wr_req_c1", dev_req, 0);
    @(negedge clk); host_go = 0;
    @(posedge clk); #2;
    check("wr_req_c2", dev_req, 3'b001);
    check("wr_addr_c2", dev_addr, 7'h2A);
    check("wr_wdata_c2", dev_wdata, 8'h5C);
    check("wr_rw_c2", dev_rw, 1);
    repeat (3) @(posedge clk);
    #2;
    check("wr_req_drop", dev_req, 0);
    @(posedge clk); #2;
    check("wr_flag_W", flag_W, 1);
    check("wr_flag_R", flag_R, 0);
    check("wr_busy_end", busy, 0);

    // Read on channel 1 returning 0xA7.
    rd_force = 1; req0_seen = 0;
    pulse_go(2'd1, 1'b0, 7'h10, 8'h00);
    @(posedge clk); #2;
    check("rd_req_c2", dev_req, 3'b010);
    repeat (3) @(posedge clk);
    #2;
    check("rd_rdata", host_rdata, 8'hA7);
    @(posedge clk); #2;
    check("rd_flag_R", flag_R, 1);
    check("rd_req0_never", req0_seen, 0);
    rd_force = 0;

    // Overflow: six pulses while the first command hangs.
    fixed_dly = 2; never_ack = 1; issued.delete();
    for (int k = 0; k < 6; k++) pulse_go(2'd0, 1'b1, 7'(8'h40 + k), 8'(k));
    check("ovf_level", fifo_level, 4);
    check("ovf_err", err_code, 1);
    never_ack = 0;
    wait_idle(200);
    check("ovf_issued_cnt", issued.size(), 5);
    for (int k = 0; k < 5 && k < issued.size(); k++)
      check("ovf_issued_order", issued[k], 32'h40 + k);

    // Timeouts.
    pulse_clr();
    check("to_err_cleared", err_code, 0);
    never_ack = 1;
    pulse_go(2'd1, 1'b1, 7'h50, 8'h11);
    pulse_go(2'd2, 1'b1, 7'h51, 8'h22);
    begin
      int i = 0;
      do begin @(posedge clk); #2; i++; end while (dev_req != '0 && i < 40);
    end
    check("to_req_cycles", last_run, 17);
    check("to_err", err_code, 2);
    @(negedge clk); never_ack = 0;
    wait_idle(100);
    check("to_next_done", flag_W, 1);
    never_ack = 1;
    pulse_go(2'd0, 1'b0, 7'h52, 8'h00);
    wait_idle(100);
    check("to_err_sticky", err_code, 2);
    never_ack = 0;
    pulse_clr();
    check("to_err_clr", err_code, 0);
    check("to_flag_clr", flag_W, 0);

    // clr_edge on the same edge that DONE sets flag_W.
    fixed_dly = 3;
    pulse_go(2'd0, 1'b1, 7'h33, 8'h44);
    repeat (4) @(negedge clk);
    host_clr = 1;
    @(posedge clk); #2;
    check("race_set_wins", flag_W, 1);
    @(negedge clk); host_clr = 0;
    @(negedge clk); host_clr = 1;
    @(posedge clk); #2;
    check("race_later_clr", flag_W, 0);
    @(negedge clk); host_clr = 0;

    // Reset during WAIT with two commands queued.
    fixed_dly = 2; never_ack = 1;
    for (int k = 0; k < 3; k++) pulse_go(2'd2, 1'b0, 7'(8'h60 + k), 8'h00);
    check("rstw_level", fifo_level, 2);
    check("rstw_req", dev_req, 3'b100);
    rst = 1;
    @(posedge clk); #2;
    check("rstw_req_drop", dev_req, 0);
    check("rstw_level0", fifo_level, 0);
    check("rstw_flags", {flag_W, flag_R}, 0);
    @(negedge clk); rst = 0; never_ack = 0;
    pulse_go(2'd1, 1'b1, 7'h7E, 8'hE7);
    @(posedge clk); #2;
    check("rstw_fresh_req", dev_req, 3'b010);
    check("rstw_fresh_addr", dev_addr, 7'h7E);
    wait_idle(50);

    // Randomized traffic.
    fixed_dly = 0; spurious = 1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      host_go    = ($urandom_range(0, 3) == 0);
      host_clr   = ($urandom_range(0, 19) == 0);
      host_chan  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      host_rw    = 1'($urandom);
      host_addr  = 7'($urandom);
      host_wdata = 8'($urandom);
    end
    @(negedge clk);
    host_go = 0; host_clr = 0; spurious = 0;
    wait_idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/host_cmd_bridge.md
Name: host_cmd_bridge

Overview:
- Parametrised successor to the FrontPanel register-access wiring.
- Host-side wire-in levels (address, data, R/W, channel, go) become queued commands. These are issued over a req/ack handshake to one of NCH downstream register engines (e.g. I2C/SPI controllers).
- Read data, per-direction done flags, error status and queue level are returned to host wire-outs.
- Sits between the okWireIn/okWireOut endpoints and the device controllers, all in the clk domain.

Parameters:
- AW, 7, register address width
- DW, 8, register data width
- NCH, 2, number of downstream channels (>=1)
- DEPTH, 4, command FIFO depth (power of 2, >=2)
- TIMEOUT, 1000000, max cycles waiting for dev_ack before abort
- CHW, derived: max(1, clog2(NCH))
- LW, derived: clog2(DEPTH+1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- host_addr  in  AW  command address
- host_wdata  in  DW  write data
- host_rw  in  1  1 = write, 0 = read
- host_chan  in  CHW  target channel
- host_go  in  1  level; rising edge enqueues one command
- host_clr  in  1  level; rising edge clears sticky flags and err_code
- host_rdata  out  DW  last read data
- flag_W  out  1  sticky: write completed
- flag_R  out  1  sticky: read completed
- err_code  out  2  sticky: 0 none, 1 overflow, 2 timeout
- busy  out  1  command pending or in flight
- fifo_level  out  LW  queued command count
- dev_req  out  NCH  one-hot request
- dev_addr  out  AW  issued address
- dev_wdata  out  DW  issued write data
- dev_rw  out  1  issued direction
- dev_ack  in  NCH  per-channel single-cycle completion
- dev_rdata  in  NCH*DW  per-channel read data, valid with ack

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, edge registers 0. Reset mid-transaction drops dev_req on the next edge and discards queued commands.
- Edge detect:
  - go_edge = host_go & ~go_q; clr_edge = host_clr & ~clr_q.
  - go_q and clr_q are registered every cycle.
- Enqueue: on go_edge, the entry {chan, rw, addr, wdata} is pushed at that edge.
  - fifo_level increments the following cycle.
  - If the FIFO is full, the command is dropped and err_code is set to 1.
  - If host_chan >= NCH, the command is dropped and err_code is set to 1.
- err_code is first-error-wins: a nonzero value is only overwritten after clr_edge.
- FSM, IDLE -> ISSUE -> WAIT -> DONE -> IDLE:
  - IDLE: if fifo_level > 0, pop the head into holding registers and go to ISSUE.
  - ISSUE: drive dev_addr/dev_wdata/dev_rw from the holding registers, assert dev_req[chan], clear the timer, go to WAIT.
  - WAIT: dev_req and the dev_* buses are held stable; the timer increments.
    - On dev_ack[chan]: deassert dev_req next edge. If rw = 0, latch dev_rdata slice chan into host_rdata. Go to DONE.
    - Acks on other channels are ignored.
    - If the timer reaches TIMEOUT-1 without ack: deassert dev_req, set err_code = 2 (if currently 0), go to IDLE. host_rdata is unchanged.
  - DONE: set flag_W (rw = 1) or flag_R (rw = 0) for one edge, then go to IDLE.
- Latency: host_go first sampled high at cycle C0 with the FIFO empty and state IDLE:
  - fifo_level = 1 at C1
  - dev_req high at C2
  - dev_ack sampled at Ca -> dev_req low and host_rdata valid at Ca+1, flag high at Ca+2
- Simultaneous push and pop: fifo_level is unchanged.
- Simultaneous clr_edge and flag/err set: the set wins.
- busy = (state != IDLE) | (fifo_level != 0).
- Commands issue strictly in FIFO order with one outstanding at a time.
- FIFO pointers wrap modulo DEPTH.

Test Plan:
- Single write: chan 0, addr 0x2A, wdata 0x5C, rw = 1, pulse host_go; device acks 3 cycles after req -> dev_req[0] high at C2 with dev_addr = 0x2A and dev_wdata = 0x5C; flag_W = 1 at ack+2; flag_R = 0; busy returns to 0.
- Read on channel 1: addr 0x10, rw = 0; device returns 0xA7 with ack -> host_rdata = 0xA7; flag_R = 1; dev_req[0] never asserts.
- Overflow: with no acks, pulse go 6 times (DEPTH = 4, first command in flight) -> fifo_level saturates at 4 and err_code = 1; acking everything afterward issues exactly 5 commands in order.
- Timeout: TIMEOUT = 16, no ack -> dev_req drops after 16 cycles in WAIT; err_code = 2; the next queued command issues normally; a second timeout leaves err_code at 2 and clr_edge returns it to 0.
- Clear race: clr_edge in the same cycle that DONE sets flag_W -> flag_W = 1; a later clr_edge -> flag_W = 0.
- Reset during WAIT with 2 commands queued -> next cycle dev_req = 0, fifo_level = 0, flags 0; a post-reset go issues a fresh command at C2.
